// File: rtl/cfg_serial_loader.sv
// Preset-table serial loader: on a start edge, shifts one CFG_WIDTH-bit word out over enable/sclk/sdata.
// Frame = 2 + SCLK_DIV + 2*SCLK_DIV*CFG_WIDTH cycles from accept to done; start edges while busy are dropped.
module cfg_serial_loader #(
   parameter int CFG_WIDTH   = 52,
   parameter int NUM_PRESETS = 8,
   parameter int SCLK_DIV    = 1,
   parameter bit MSB_FIRST   = 1'b0,
   localparam int IDX_W      = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             auto_inc,
   input  logic [IDX_W-1:0]                 preset_sel,
   input  logic [NUM_PRESETS*CFG_WIDTH-1:0] presets,
   output logic                             enable,
   output logic                             sclk,
   output logic                             sdata,
   output logic                             busy,
   output logic                             done,
   output logic [IDX_W-1:0]                 cur_index
);

   localparam int CNT_W = $clog2(CFG_WIDTH);
   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_WIDTH - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCLK_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PRESETS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_END
   } state_t;

   state_t               state;
   state_t               next_state;
   logic                 start_q;
   logic [CFG_WIDTH-1:0] shreg;
   logic [CNT_W-1:0]     bit_cnt;
   logic [DIV_W-1:0]     div_cnt;
   logic                 auto_q;
   logic                 accept;
   logic                 div_last;
   logic                 bit_last;
   logic [IDX_W-1:0]     sel_raw;
   logic [IDX_W-1:0]     sel_idx;
   logic [CFG_WIDTH-1:0] sel_word;

   assign accept   = start & ~start_q & (state == S_IDLE);
   assign div_last = (div_cnt == LAST_DIV);
   assign bit_last = (bit_cnt == LAST_BIT);

   // Out-of-range explicit selections fall back to entry 0.
   always_comb begin
      sel_raw  = auto_inc ? cur_index : preset_sel;
      sel_idx  = (32'(sel_raw) < NUM_PRESETS) ? sel_raw : '0;
      sel_word = presets[sel_idx*CFG_WIDTH +: CFG_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      enable     = 1'b0;
      sclk       = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      sdata      = MSB_FIRST ? shreg[CFG_WIDTH-1] : shreg[0];
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (accept) next_state = S_LOAD;
         end
         S_LOAD: begin
            next_state = S_SETUP;
         end
         S_SETUP: begin
            enable = 1'b1;
            if (div_last) next_state = S_HIGH;
         end
         S_HIGH: begin
            enable = 1'b1;
            sclk   = 1'b1;
            if (div_last) next_state = S_LOW;
         end
         S_LOW: begin
            enable = 1'b1;
            if (div_last) next_state = bit_last ? S_END : S_HIGH;
         end
         S_END: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         start_q   <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         auto_q    <= 1'b0;
         cur_index <= '0;
      end else begin
         start_q <= start;
         case (state)
            S_LOAD: begin
               shreg   <= sel_word;
               bit_cnt <= '0;
               div_cnt <= '0;
               auto_q  <= auto_inc;
            end
            S_SETUP, S_HIGH: begin
               div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            end
            S_LOW: begin
               div_cnt <= div_last ? '0 : div_cnt + 1'b1;
               // Zero-fill leaves shreg clear after the last bit, so sdata idles low.
               if (div_last) begin
                  shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                  if (!bit_last) bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_END: begin
               if (auto_q) cur_index <= (cur_index == LAST_IDX) ? '0 : cur_index + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Randomized bench for cfg_serial_loader: two configurations checked against a frame-level reference model.
module tb_cfg_serial_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Instance A: defaults (52-bit, 8 presets, div 1, LSB first)
   logic         a_reset, a_start, a_auto;
   logic [2:0]   a_sel;
   logic [415:0] a_presets;
   logic         a_enable, a_sclk, a_sdata, a_busy, a_done;
   logic [2:0]   a_cur;
   logic [51:0]  a_tab [8];

   // Instance B: 8-bit, 5 presets, div 3, MSB first
   logic         b_reset, b_start, b_auto;
   logic [2:0]   b_sel;
   logic [39:0]  b_presets;
   logic         b_enable, b_sclk, b_sdata, b_busy, b_done;
   logic [2:0]   b_cur;
   logic [7:0]   b_tab [5];

   always_comb begin
      a_presets = '0;
      for (int i = 0; i < 8; i++) a_presets[i*52 +: 52] = a_tab[i];
   end

   always_comb begin
      b_presets = '0;
      for (int i = 0; i < 5; i++) b_presets[i*8 +: 8] = b_tab[i];
   end

   cfg_serial_loader u_a (
      .clk        (clk),
      .reset      (a_reset),
      .start      (a_start),
      .auto_inc   (a_auto),
      .preset_sel (a_sel),
      .presets    (a_presets),
      .enable     (a_enable),
      .sclk       (a_sclk),
      .sdata      (a_sdata),
      .busy       (a_busy),
      .done       (a_done),
      .cur_index  (a_cur)
   );

   cfg_serial_loader #(
      .CFG_WIDTH   (8),
      .NUM_PRESETS (5),
      .SCLK_DIV    (3),
      .MSB_FIRST   (1'b1)
   ) u_b (
      .clk        (clk),
      .reset      (b_reset),
      .start      (b_start),
      .auto_inc   (b_auto),
      .preset_sel (b_sel),
      .presets    (b_presets),
      .enable     (b_enable),
      .sclk       (b_sclk),
      .sdata      (b_sdata),
      .busy       (b_busy),
      .done       (b_done),
      .cur_index  (b_cur)
   );

   int         inst_sel = 0;
   int         model_idx [2];
   logic       m_enable, m_sclk, m_sdata, m_busy, m_done;
   logic [2:0] m_cur;

   always_comb begin
      if (inst_sel == 1) begin
         {m_enable, m_sclk, m_sdata, m_busy, m_done} = {b_enable, b_sclk, b_sdata, b_busy, b_done};
         m_cur = b_cur;
      end else begin
         {m_enable, m_sclk, m_sdata, m_busy, m_done} = {a_enable, a_sclk, a_sdata, a_busy, a_done};
         m_cur = a_cur;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int inst, input logic st, input logic au, input logic [2:0] se);
      if (inst == 1) begin
         b_start = st; b_auto = au; b_sel = se;
      end else begin
         a_start = st; a_auto = au; a_sel = se;
      end
   endtask

   // One frame: start edge, monitor every cycle, compare against the reference model.
   task automatic run_frame(input int inst, input int auto_v, input int sel_v, input int retrig,
                            input int hold, input int flip_auto_at, input int chg_tab_at, input string tag);
      int          w, d, n, msb, exp_idx, done_exp, limit;
      int          edges, hi_run, lo_run, hi_bad, lo_bad, busy_bad, extra_busy, done_cnt, done_at;
      logic        prev_sclk, st, au;
      logic [63:0] obs, expw;
      inst_sel = inst;
      w   = (inst == 1) ? 8 : 52;
      d   = (inst == 1) ? 3 : 1;
      n   = (inst == 1) ? 5 : 8;
      msb = inst;
      exp_idx  = (auto_v != 0) ? model_idx[inst] : ((sel_v < n) ? sel_v : 0);
      expw     = (inst == 1) ? 64'(b_tab[exp_idx]) : 64'(a_tab[exp_idx]);
      done_exp = 1 + d + 2*d*w;
      limit    = ((hold > done_exp) ? hold : done_exp) + 12;
      au       = (auto_v != 0);
      edges = 0; hi_run = 0; lo_run = 0; hi_bad = 0; lo_bad = 0;
      busy_bad = 0; extra_busy = 0; done_cnt = 0; done_at = -1;
      obs = '0; prev_sclk = 1'b0;
      drive(inst, 1'b1, au, 3'(sel_v));
      @(posedge clk); #1;
      for (int cyc = 0; cyc <= limit; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         st = (hold > 0) ? (cyc < hold) : (retrig > 0 && cyc >= retrig && cyc < retrig + 5);
         if (flip_auto_at > 0 && cyc == flip_auto_at) au = ~au;
         drive(inst, st, au, (cyc >= 2) ? 3'($urandom) : 3'(sel_v));
         if (chg_tab_at > 0 && cyc == chg_tab_at) begin
            for (int i = 0; i < 8; i++) a_tab[i] = (inst == 1) ? a_tab[i] : 52'({$urandom, $urandom});
            for (int i = 0; i < 5; i++) b_tab[i] = (inst == 1) ? 8'($urandom) : b_tab[i];
         end
         if (m_sclk && !prev_sclk) begin
            if (edges < w) obs[(msb == 1) ? (w - 1 - edges) : edges] = m_sdata;
            edges++;
            if (lo_run != d) lo_bad++;
            lo_run = 0;
         end
         if (m_sclk) begin
            hi_run++;
         end else begin
            if (prev_sclk) begin
               if (hi_run != d) hi_bad++;
               hi_run = 0;
            end
            if (m_enable) lo_run++;
         end
         if (m_done) begin
            done_cnt++;
            done_at = cyc;
            if (lo_run != d) lo_bad++;
         end
         if (cyc <= done_exp && !m_busy) busy_bad++;
         if (cyc > done_exp && m_busy) extra_busy++;
         prev_sclk = m_sclk;
      end
      if (auto_v != 0) model_idx[inst] = (model_idx[inst] + 1) % n;
      chk({tag, "_edges"}, 64'(edges), 64'(w));
      chk({tag, "_bits"}, obs, expw);
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      chk({tag, "_done_at"}, 64'(done_at), 64'(done_exp));
      chk({tag, "_hi_len"}, 64'(hi_bad), 64'd0);
      chk({tag, "_lo_len"}, 64'(lo_bad), 64'd0);
      chk({tag, "_busy_gap"}, 64'(busy_bad), 64'd0);
      chk({tag, "_busy_extra"}, 64'(extra_busy), 64'd0);
      chk({tag, "_cur_index"}, 64'(m_cur), 64'(model_idx[inst]));
      chk({tag, "_idle_sdata"}, 64'(m_sdata), 64'd0);
   endtask

   initial begin
      int   edges, dn, bb;
      logic prev;
      a_tab[0] = 52'h0F07FC4008080;
      for (int i = 1; i < 8; i++) a_tab[i] = 52'({$urandom, $urandom});
      for (int i = 0; i < 5; i++) b_tab[i] = 8'($urandom);
      b_tab[0] = 8'h3C;
      b_tab[2] = 8'hA5;
      model_idx[0] = 0;
      model_idx[1] = 0;
      a_reset = 1'b1; b_reset = 1'b1;
      drive(0, 1'b0, 1'b0, 3'd0);
      drive(1, 1'b0, 1'b0, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_enable", 64'(a_enable), 64'd0);
      chk("rst_a_sclk",   64'(a_sclk),   64'd0);
      chk("rst_a_sdata",  64'(a_sdata),  64'd0);
      chk("rst_a_busy",   64'(a_busy),   64'd0);
      chk("rst_a_done",   64'(a_done),   64'd0);
      chk("rst_a_cur",    64'(a_cur),    64'd0);
      chk("rst_b_enable", 64'(b_enable), 64'd0);
      chk("rst_b_sclk",   64'(b_sclk),   64'd0);
      chk("rst_b_busy",   64'(b_busy),   64'd0);
      chk("rst_b_cur",    64'(b_cur),    64'd0);
      a_reset = 1'b0; b_reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Auto-increment sweep: 9 frames, wraps after the 8th
      run_frame(0, 1, 0, 0, 0, 0, 0, "a_f1");
      for (int k = 2; k <= 9; k++) run_frame(0, 1, 0, 0, 0, 0, 0, $sformatf("a_f%0d", k));
      run_frame(0, 1, 0, 20, 0, 0, 20, "a_retrig");
      run_frame(0, 0, int'($urandom_range(0, 7)), 0, 500, 30, 0, "a_hold");
      run_frame(0, 1, 0, 0, 0, 30, 0, "a_flip");

      // Reset at the 30th sclk rising edge of a frame
      inst_sel = 0;
      drive(0, 1'b1, 1'b1, 3'd0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 3'd0);
      edges = 0; dn = 0; bb = 0; prev = 1'b0;
      for (int c = 0; c < 300 && edges < 30; c++) begin
         @(posedge clk); #1;
         if (a_sclk && !prev) edges++;
         if (a_done) dn++;
         prev = a_sclk;
      end
      chk("mid_rst_edge30", 64'(edges), 64'd30);
      a_reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_enable", 64'(a_enable), 64'd0);
      chk("mid_rst_sclk",   64'(a_sclk),   64'd0);
      chk("mid_rst_sdata",  64'(a_sdata),  64'd0);
      chk("mid_rst_busy",   64'(a_busy),   64'd0);
      chk("mid_rst_cur",    64'(a_cur),    64'd0);
      a_reset = 1'b0;
      model_idx[0] = 0;
      for (int c = 0; c < 150; c++) begin
         @(posedge clk); #1;
         if (a_done) dn++;
         if (a_busy) bb++;
      end
      chk("mid_rst_no_done", 64'(dn), 64'd0);
      chk("mid_rst_idle", 64'(bb), 64'd0);
      run_frame(0, 1, 0, 0, 0, 0, 0, "a_after_rst");
      for (int k = 0; k < 4; k++)
         run_frame(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0, 0, 0, 0, $sformatf("a_rnd%0d", k));

      // MSB-first, divided clock, 5-entry table
      run_frame(1, 0, 2, 0, 0, 0, 0, "b_a5");
      for (int s = 5; s <= 7; s++) run_frame(1, 0, s, 0, 0, 0, 0, $sformatf("b_oor%0d", s));
      for (int k = 0; k < 6; k++) run_frame(1, 1, 0, 0, 0, 0, 0, $sformatf("b_auto%0d", k));
      for (int k = 0; k < 3; k++)
         run_frame(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0, 0, 0, 0, $sformatf("b_rnd%0d", k));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
